// File: rtl/mul_array_pipe_pkg.sv
// Shared constants and helpers for the lane-parallel multiplier array.
package mul_array_pipe_pkg;

  // Default geometry of the conv datapath multiplier array.
  localparam int MAX_W_DEF = 3;
  localparam int LANES_DEF = 36;

  // op_bits is a fixed 3-bit field; zero is never a legal precision.
  localparam int                   OP_BITS_W    = 3;
  localparam logic [OP_BITS_W-1:0] OP_BITS_ZERO = '0;

  // Full-precision product width for a given operand width.
  function automatic int prod_width(input int max_w);
    return 2 * max_w;
  endfunction

  // Low bit index of lane `lane` in a packed vector of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mul_lane.sv
// One multiplier lane: operand conditioning, registered operands (S1) and
// registered full-precision product (S2).
module mul_lane
  import mul_array_pipe_pkg::*;
#(
  parameter int MAX_W  = MAX_W_DEF,
  parameter int PROD_W = prod_width(MAX_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s1_load,    // input transfer this cycle
  input  logic                 s2_load,    // S1 contents move into S2 this cycle
  input  logic                 lane_en,
  input  logic                 sign_en,    // input-side signedness (already gated)
  input  logic                 s1_signed,  // signedness of the transaction held in S1
  input  logic [OP_BITS_W-1:0] eff_bits,
  input  logic [MAX_W-1:0]     op_a,
  input  logic [MAX_W-1:0]     op_b,
  output logic [PROD_W-1:0]    prod
);

  logic [MAX_W-1:0]  a_q, b_q;
  logic              en_q;
  logic [MAX_W-1:0]  a_cond, b_cond;
  logic [PROD_W-1:0] a_ext, b_ext, mult;
  logic [PROD_W-1:0] prod_q;

  // Keep the low eff_bits bits, then zero- or sign-extend from bit eff_bits-1.
  function automatic logic [MAX_W-1:0] condition(input logic [MAX_W-1:0]     op,
                                                 input logic [OP_BITS_W-1:0] bits,
                                                 input logic                 sgn);
    logic [MAX_W-1:0] res;
    logic             msb;
    // NOTE: every variable gets a default before any conditional write, so
    // combinational logic built from this never infers a latch.
    res = '0;
    msb = 1'b0;
    for (int i = 0; i < MAX_W; i++)
      if (i == int'(bits) - 1) msb = op[i];
    for (int i = 0; i < MAX_W; i++)
      res[i] = (i < int'(bits)) ? op[i] : (sgn & msb);
    return res;
  endfunction

  assign a_cond = condition(op_a, eff_bits, sign_en);
  assign b_cond = condition(op_b, eff_bits, sign_en);

  // S1 operand capture; a disabled lane keeps its old operands so nothing toggles.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. These data
    // registers are qualified by the pipeline valid bits and need no reset.
    if (s1_load) begin
      en_q <= lane_en;
      if (lane_en) begin
        a_q <= a_cond;
        b_q <= b_cond;
      end
    end
  end

  // Extend to product width; low PROD_W bits of the product are exact either way.
  assign a_ext = {{MAX_W{s1_signed & a_q[MAX_W-1]}}, a_q};
  assign b_ext = {{MAX_W{s1_signed & b_q[MAX_W-1]}}, b_q};
  assign mult  = a_ext * b_ext;

  // S2 product register; disabled lanes present zero.
  always_ff @(posedge clk) begin
    if (reset)        prod_q <= '0;
    else if (s2_load) prod_q <= en_q ? mult : '0;
  end

  assign prod = prod_q;

endmodule

// File: rtl/mul_array_pipe.sv
// Two-stage elastic lane-parallel multiplier array with runtime precision,
// signedness and per-lane enable. Owns the valid/ready handshake.
module mul_array_pipe
  import mul_array_pipe_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int MAX_W     = MAX_W_DEF,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_BITS_W-1:0]     op_bits,
  input  logic                     is_signed,
  input  logic [LANES-1:0]         lane_en,
  input  logic [LANES*MAX_W-1:0]   op_a,
  input  logic [LANES*MAX_W-1:0]   op_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*2*MAX_W-1:0] prod,
  output logic [OP_BITS_W-1:0]     out_bits,
  output logic                     out_err
);

  localparam int PROD_W = prod_width(MAX_W);

  logic                 s1_valid_q, s1_err_q, s1_signed_q;
  logic [OP_BITS_W-1:0] s1_bits_q;
  logic                 out_valid_q, out_err_q;
  logic [OP_BITS_W-1:0] out_bits_q;

  logic                 s2_adv, s1_adv, in_fire, s2_load;
  logic                 bits_legal, sign_eff;
  logic [OP_BITS_W-1:0] eff_bits;

  // Stage advance chain; in_ready is combinational from out_ready.
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && !reset;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_adv;

  // Illegal precision falls back to full width and flags the result.
  assign bits_legal = (op_bits != OP_BITS_ZERO) && (int'(op_bits) <= MAX_W);
  assign eff_bits   = bits_legal ? op_bits : OP_BITS_W'(MAX_W);
  assign sign_eff   = SIGNED_EN && is_signed;

  // S1 occupancy: refilled (or emptied) whenever the stage may advance.
  always_ff @(posedge clk) begin
    if (reset)       s1_valid_q <= 1'b0;
    else if (s1_adv) s1_valid_q <= in_fire;
  end

  // S1 transaction attributes, captured with the operands.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_bits_q   <= eff_bits;
      s1_err_q    <= !bits_legal;
      s1_signed_q <= sign_eff;
    end
  end

  // S2 occupancy and output attributes; held while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_err_q   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_bits_q <= s1_bits_q;
        out_err_q  <= s1_err_q;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mul_lane #(
      .MAX_W (MAX_W),
      .PROD_W(PROD_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .s1_load  (in_fire),
      .s2_load  (s2_load),
      .lane_en  (lane_en[i]),
      .sign_en  (sign_eff),
      .s1_signed(s1_signed_q),
      .eff_bits (eff_bits),
      .op_a     (op_a[lane_lo(i, MAX_W) +: MAX_W]),
      .op_b     (op_b[lane_lo(i, MAX_W) +: MAX_W]),
      .prod     (prod[lane_lo(i, PROD_W) +: PROD_W])
    );
  end

  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_mul_array_pipe.sv
// Self-checking bench for mul_array_pipe: directed cases plus randomized
// traffic checked against an arithmetic reference model and scoreboard.
module tb_mul_array_pipe;

  localparam int LANES = 36;
  localparam int MAX_W = 3;
  localparam int PW    = 2 * MAX_W;
  localparam int AW    = LANES * MAX_W;
  localparam int PRW   = LANES * PW;

  typedef struct {
    logic [2:0]       bits;
    logic             sgn;
    logic [LANES-1:0] en;
    logic [AW-1:0]    a;
    logic [AW-1:0]    b;
  } txn_t;

  typedef struct {
    logic [PRW-1:0] prod;
    logic [2:0]     bits;
    logic           err;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [2:0]       op_bits;
  logic             is_signed;
  logic [LANES-1:0] lane_en;
  logic [AW-1:0]    op_a, op_b;
  logic             out_valid, out_ready;
  logic [PRW-1:0]   prod;
  logic [2:0]       out_bits;
  logic             out_err;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  bit   rand_done;
  exp_t sb_q[$];

  mul_array_pipe #(.LANES(LANES), .MAX_W(MAX_W), .SIGNED_EN(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_bits  (op_bits),
    .is_signed(is_signed),
    .lane_en  (lane_en),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .prod     (prod),
    .out_bits (out_bits),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PRW-1:0] got, input logic [PRW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] lane_p(input logic [PRW-1:0] p, input int i);
    return p[i*PW +: PW];
  endfunction

  // Reference: interpret each operand as an integer of eff bits, multiply, keep 2*MAX_W bits.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    int   eff, av, bv, p;
    eff    = (t.bits == 3'd0 || int'(t.bits) > MAX_W) ? MAX_W : int'(t.bits);
    e.bits = 3'(eff);
    e.err  = (eff != int'(t.bits));
    e.prod = '0;
    for (int i = 0; i < LANES; i++) begin
      if (t.en[i]) begin
        av = int'(t.a[i*MAX_W +: MAX_W]) % (1 << eff);
        bv = int'(t.b[i*MAX_W +: MAX_W]) % (1 << eff);
        if (t.sgn && av >= (1 << (eff - 1))) av -= (1 << eff);
        if (t.sgn && bv >= (1 << (eff - 1))) bv -= (1 << eff);
        p = av * bv;
        e.prod[i*PW +: PW] = PW'(p);
      end
    end
    return e;
  endfunction

  function automatic txn_t uniform(input logic [2:0] bits, input logic sgn,
                                   input logic [LANES-1:0] en, input logic [MAX_W-1:0] av,
                                   input logic [MAX_W-1:0] bv);
    txn_t t;
    t.bits = bits; t.sgn = sgn; t.en = en;
    for (int i = 0; i < LANES; i++) begin
      t.a[i*MAX_W +: MAX_W] = av;
      t.b[i*MAX_W +: MAX_W] = bv;
    end
    return t;
  endfunction

  function automatic txn_t random_txn();
    txn_t t;
    t.bits = 3'($urandom_range(0, 7));
    t.sgn  = 1'($urandom_range(0, 1));
    for (int i = 0; i < LANES; i++) begin
      t.en[i]               = ($urandom_range(0, 7) != 0);
      t.a[i*MAX_W +: MAX_W] = MAX_W'($urandom);
      t.b[i*MAX_W +: MAX_W] = MAX_W'($urandom);
    end
    return t;
  endfunction

  // Scoreboard: pop on output transfer, push model result on input transfer.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          check("sb_spurious_output", PRW'(1), PRW'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_prod", prod, e.prod);
          check("sb_bits", PRW'(out_bits), PRW'(e.bits));
          check("sb_err", PRW'(out_err), PRW'(e.err));
        end
      end else if (out_valid && sb_q.size() != 0) begin
        check("stall_prod_stable", prod, sb_q[0].prod);
        check("stall_bits_stable", PRW'(out_bits), PRW'(sb_q[0].bits));
      end
      if (in_valid && in_ready) begin
        txn_t t;
        t.bits = op_bits; t.sgn = is_signed; t.en = lane_en; t.a = op_a; t.b = op_b;
        sb_q.push_back(model(t));
      end
    end
  end

  task automatic apply(input txn_t t);
    in_valid  = 1'b1;
    op_bits   = t.bits;
    is_signed = t.sgn;
    lane_en   = t.en;
    op_a      = t.a;
    op_b      = t.b;
  endtask

  // Present a transaction (called just after a rising edge) and hold it until accepted.
  task automatic send(input txn_t t);
    bit ok;
    ok = 1'b0;
    apply(t);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) check("in_ready_timeout", PRW'(0), PRW'(1));
    in_valid = 1'b0;
  endtask

  // Wait for the next output transfer and return its product.
  task automatic get_out(output logic [PRW-1:0] p);
    bit ok;
    ok = 1'b0;
    p  = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        ok = 1'b1;
        p  = prod;
      end
    end
    if (!ok) check("out_valid_timeout", PRW'(0), PRW'(1));
  endtask

  initial begin
    logic [PRW-1:0] p;
    txn_t           t;
    int             base;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_bits = '0; is_signed = 1'b0; lane_en = '0; op_a = '0; op_b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", PRW'(out_valid), PRW'(0));
    check("rst_prod", prod, PRW'(0));
    check("rst_out_bits", PRW'(out_bits), PRW'(0));
    check("rst_out_err", PRW'(out_err), PRW'(0));
    check("rst_in_ready", PRW'(in_ready), PRW'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", PRW'(in_ready), PRW'(1));

    // Unsigned 2-bit: presented in the cycle after edge k, result visible after edge k+2.
    t = random_txn();
    t.bits = 3'd2; t.sgn = 1'b0; t.en = '1;
    t.a[2:0] = 3'd3; t.b[2:0] = 3'd3;
    t.a[5:3] = 3'd2; t.b[5:3] = 3'd1;
    @(posedge clk); #1 apply(t);
    @(negedge clk);
    check("u2_in_ready", PRW'(in_ready), PRW'(1));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("u2_latency_not_early", PRW'(out_valid), PRW'(0));
    @(negedge clk);
    check("u2_out_valid", PRW'(out_valid), PRW'(1));
    check("u2_lane0", PRW'(lane_p(prod, 0)), PRW'(9));
    check("u2_lane1", PRW'(lane_p(prod, 1)), PRW'(2));
    check("u2_out_bits", PRW'(out_bits), PRW'(2));
    check("u2_out_err", PRW'(out_err), PRW'(0));

    // Signed 3-bit
    @(posedge clk); #1;
    t = uniform(3'd3, 1'b1, '1, 3'd0, 3'd0);
    t.a[2:0] = 3'b111; t.b[2:0] = 3'b011;
    t.a[5:3] = 3'b100; t.b[5:3] = 3'b100;
    send(t);
    get_out(p);
    check("s3_lane0", PRW'(lane_p(p, 0)), PRW'(6'b111101));
    check("s3_lane1", PRW'(lane_p(p, 1)), PRW'(16));

    // Illegal precision, then a legal one
    send(uniform(3'd0, 1'b0, '1, 3'd7, 3'd7));
    get_out(p);
    check("ill0_lane0", PRW'(lane_p(p, 0)), PRW'(49));
    check("ill0_lane35", PRW'(lane_p(p, 35)), PRW'(49));
    check("ill0_bits", PRW'(out_bits), PRW'(3));
    check("ill0_err", PRW'(out_err), PRW'(1));
    send(uniform(3'd5, 1'b0, '1, 3'd7, 3'd7));
    get_out(p);
    check("ill5_lane7", PRW'(lane_p(p, 7)), PRW'(49));
    check("ill5_bits", PRW'(out_bits), PRW'(3));
    check("ill5_err", PRW'(out_err), PRW'(1));
    send(uniform(3'd3, 1'b0, '1, 3'd7, 3'd7));
    get_out(p);
    check("legal_after_ill_err", PRW'(out_err), PRW'(0));
    check("legal_after_ill_lane0", PRW'(lane_p(p, 0)), PRW'(49));

    // Lane enable: lane 5 off must keep its previously captured operand
    send(uniform(3'd3, 1'b0, '1, 3'd1, 3'd2));
    get_out(p);
    send(uniform(3'd2, 1'b0, ~(LANES'(1) << 5), 3'd3, 3'd3));
    check("lane5_s1_hold", PRW'(dut.g_lane[5].u_lane.a_q), PRW'(1));
    check("lane4_s1_load", PRW'(dut.g_lane[4].u_lane.a_q), PRW'(3));
    get_out(p);
    check("lane5_prod_zero", PRW'(lane_p(p, 5)), PRW'(0));
    check("lane4_prod", PRW'(lane_p(p, 4)), PRW'(9));
    check("lane0_prod", PRW'(lane_p(p, 0)), PRW'(9));

    // Backpressure: stall the output for 4 cycles while streaming 5 transactions
    repeat (3) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b0;
    base = n_out;
    send(random_txn());
    send(random_txn());
    apply(random_txn());
    @(negedge clk);
    check("bp_in_ready_low", PRW'(in_ready), PRW'(0));
    check("bp_out_valid", PRW'(out_valid), PRW'(1));
    repeat (2) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    t.bits = op_bits; t.sgn = is_signed; t.en = lane_en; t.a = op_a; t.b = op_b;
    send(t);
    send(random_txn());
    send(random_txn());
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("bp_output_count", PRW'(n_out - base), PRW'(5));

    // Reset mid-flight discards in-flight transactions
    @(posedge clk); #1;
    send(random_txn());
    send(random_txn());
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_out_valid", PRW'(out_valid), PRW'(0));
    check("midrst_prod", prod, PRW'(0));
    check("midrst_in_ready", PRW'(in_ready), PRW'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_release_in_ready", PRW'(in_ready), PRW'(1));
    base = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) base++;
      @(negedge clk);
    end
    check("midrst_no_stale", PRW'(base), PRW'(0));

    // Randomized traffic with random backpressure
    rand_done = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(random_txn());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("final_drain", PRW'(sb_q.size()), PRW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_array_pipe.md
Name: mul_array_pipe

Overview:
- Parametrised, pipelined lane-parallel multiplier array for the conv datapath.
- Sits between the filter/scatter stage and the accumulate stage.
- Generalises the fixed 2-bit/3-bit multiplier banks into one array of LANES lanes.
- Runtime-selectable operand precision (1..MAX_W bits) and signedness.
- valid/ready handshake with full backpressure; per-lane enable for power gating.

Parameters:
LANES, 36, number of parallel multiplier lanes
MAX_W, 3, maximum operand width in bits; product lane width is 2*MAX_W
SIGNED_EN, 1, 1 = signed mode supported; 0 = is_signed input ignored (always unsigned)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input transaction valid
in_ready  output  1  array can accept input this cycle
op_bits  input  3  operand precision for this transaction, legal 1..MAX_W
is_signed  input  1  operands are two's complement of op_bits width
lane_en  input  LANES  per-lane enable; disabled lanes produce 0
op_a  input  LANES*MAX_W  lane i operand A at [i*MAX_W +: MAX_W]
op_b  input  LANES*MAX_W  lane i operand B at [i*MAX_W +: MAX_W]
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
prod  output  LANES*2*MAX_W  lane i product at [i*2*MAX_W +: 2*MAX_W]
out_bits  output  3  effective op_bits used for this result
out_err  output  1  op_bits was illegal for this transaction

Behaviour:
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Two-stage elastic pipeline:
  - S1 registers the conditioned operands, lane_en, effective bits and err.
  - S2 registers the products. S2 drives all outputs directly from registers.
- Latency and throughput:
  - Latency is 2 cycles. A transaction accepted at edge k has out_valid=1 after edge k+2, provided out_ready was not stalling.
  - Throughput is 1 transaction per cycle when out_ready stays 1.
- Pipeline advance:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !reset. The path is combinational from out_ready.
- Stall behaviour:
  - When out_ready=0, S2 holds prod, out_bits and out_err stable while out_valid=1.
  - S1 fills, then in_ready drops.
  - No transaction is dropped or duplicated.
- Operand conditioning (S1 input side):
  - Mask each operand to its low eff_bits bits.
  - Unsigned: zero-extend to MAX_W.
  - Signed (is_signed && SIGNED_EN): sign-extend from bit eff_bits-1.
- op_bits legality:
  - op_bits==0 or op_bits>MAX_W: eff_bits=MAX_W, out_err=1 for that result only. Data is still computed.
- Product width:
  - Full-precision product, 2*MAX_W bits, never truncated or saturated.
  - Unsigned results are zero-extended; signed results are sign-extended.
- Disabled lanes:
  - A lane with lane_en[i]=0 outputs prod lane = 0.
  - Its S1 operand registers hold their previous value (no toggle).
- Simultaneous events:
  - Input accept and output drain in the same cycle with both stages full: both happen, occupancy unchanged.
- Reset (synchronous):
  - out_valid=0, prod=0, out_bits=0, out_err=0, S1 valid=0, in_ready=0 while reset is high.
  - in_ready=1 on the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight transactions; no output is produced for them.
- Output stability: outputs change only on clock edges.

Decomposition:
- Shared package holds:
  - default constants MAX_W_DEF=3, LANES_DEF=36
  - localparam PROD_W = 2*MAX_W
  - op_bits encoding constants
  - lane slice index helper function
- One sub-module, mul_lane:
  - one lane's operand conditioning plus multiply, with registered operand and product stages gated by stage advance and lane_en.
  - mul_array_pipe instantiates LANES copies in a generate loop and owns the handshake/valid logic.

Test Plan:
- Unsigned 2-bit, LANES=36, all lanes enabled, op_bits=2, lane0 a=3 b=3, lane1 a=2 b=1, out_ready=1 -> two cycles after accept, prod lane0=9, lane1=2, out_bits=2, out_err=0.
- Signed 3-bit, op_bits=3, is_signed=1, lane0 a=3'b111 (-1) b=3'b011 (3), lane1 a=3'b100 (-4) b=3'b100 (-4) -> lane0=6'b111101 (-3), lane1=6'd16.
- Backpressure: stream 5 back-to-back transactions with out_ready held 0 for 4 cycles -> in_ready drops after 2 accepts, prod held stable, then all 5 results emerge in order with no loss or duplication.
- Illegal precision: op_bits=0 and op_bits=5 with MAX_W=3, a=7 b=7 unsigned -> prod=49, out_bits=3, out_err=1; next legal transaction has out_err=0.
- Lane enable: lane_en=all ones except lane 5 = 0, a=b=3 on all lanes -> lane5 prod=0, other lanes=9; lane5 S1 registers unchanged.
- Reset mid-flight: accept 2 transactions, assert reset 1 cycle -> out_valid=0, prod=0 while reset; no stale results after release; in_ready=1 the cycle after reset deasserts.
